// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the mux scan sequencer.
// The dwell helper folds a programmed dwell of 0 into 1.
package mux_scan_pkg;

  localparam int NUM_CH = 4;
  localparam int CH_W   = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    DONE   = 2'd2
  } scan_state_t;

  // Terminal count of the dwell counter; dwell 0 behaves like dwell 1.
  function automatic int dwell_last(input int dwell);
    return (dwell < 1) ? 0 : dwell - 1;
  endfunction

endpackage

// File: rtl/scan_dwell_cnt.sv
// Dwell counter: counts while enabled, wraps to 0 on its terminal value.
// The term flag marks the cycle on which the mux output is sampled.
module scan_dwell_cnt
  import mux_scan_pkg::*;
#(
  parameter int CNT_W = 8,
  parameter int DWELL = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic term
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(dwell_last(DWELL));

  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;

  assign term = (cnt_reg == LAST);

  always_comb begin
    cnt_next = cnt_reg;
    if (clr) begin
      cnt_next = '0;
    end else if (en) begin
      cnt_next = term ? '0 : cnt_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

endmodule

// File: rtl/mux_scan_ctrl.sv
// Scan sequencer for a 4:1 mux: steps the selects through all channels,
// samples y after each dwell and publishes the four samples as a snapshot.
module mux_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter int DWELL = 2,
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              continuous,
  input  logic              y,
  output logic              S0,
  output logic              S1,
  output logic              busy,
  output logic              done,
  output logic [NUM_CH-1:0] snap,
  output logic              snap_valid
);

  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

  scan_state_t           state_reg, state_next;
  logic [CH_W-1:0]       ch_reg, ch_next;
  logic [NUM_CH-2:0]     shadow_reg, shadow_next;
  logic [NUM_CH-1:0]     snap_reg, snap_next;
  logic                  snap_valid_reg, snap_valid_next;
  logic                  busy_reg, done_reg;
  logic                  dwell_term;

  scan_dwell_cnt #(
    .CNT_W (CNT_W),
    .DWELL (DWELL)
  ) u_dwell (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state_reg != SETTLE),
    .en    (state_reg == SETTLE),
    .term  (dwell_term)
  );

  always_comb begin
    state_next      = state_reg;
    ch_next         = ch_reg;
    shadow_next     = shadow_reg;
    snap_next       = snap_reg;
    snap_valid_next = snap_valid_reg;
    unique case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = SETTLE;
          ch_next    = '0;
        end
      end
      SETTLE: begin
        if (dwell_term) begin
          if (ch_reg == LAST_CH) begin
            // Last channel goes straight into the snapshot with the shadows.
            state_next      = DONE;
            snap_next       = {y, shadow_reg};
            snap_valid_next = 1'b1;
          end else begin
            for (int i = 0; i < NUM_CH - 1; i++) begin
              if (ch_reg == CH_W'(i)) begin
                shadow_next[i] = y;
              end
            end
            ch_next = ch_reg + CH_W'(1);
          end
        end
      end
      DONE: begin
        state_next = continuous ? SETTLE : IDLE;
        ch_next    = '0;
      end
      default: begin
        state_next = IDLE;
        ch_next    = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      ch_reg         <= '0;
      shadow_reg     <= '0;
      snap_reg       <= '0;
      snap_valid_reg <= 1'b0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      ch_reg         <= ch_next;
      shadow_reg     <= shadow_next;
      snap_reg       <= snap_next;
      snap_valid_reg <= snap_valid_next;
      busy_reg       <= (state_next == SETTLE);
      done_reg       <= (state_next == DONE);
    end
  end

  // The channel register is the select itself; it reads 11 in DONE, 00 in IDLE.
  assign {S1, S0}   = ch_reg;
  assign busy       = busy_reg;
  assign done       = done_reg;
  assign snap       = snap_reg;
  assign snap_valid = snap_valid_reg;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Bench for mux_scan_ctrl: three instances (DWELL 0,1,2), each beside a 4:1 mux,
// checked against scan timing and snapshot values derived arithmetically.
module tb_mux_scan_ctrl;

  logic       clk;
  logic       rst_n;
  logic [2:0] start_v;
  logic [2:0] cont_v;
  logic [3:0] in_v [3];
  logic [2:0] y_w, s0_w, s1_w, busy_w, done_w, sv_w;
  logic [3:0] snap_w [3];
  logic [3:0] last_snap [3];

  int n_cmp = 0;
  int n_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    assign y_w[gi] = in_v[gi][{s1_w[gi], s0_w[gi]}];

    mux_scan_ctrl #(
      .DWELL (gi),
      .CNT_W (8)
    ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start_v[gi]),
      .continuous (cont_v[gi]),
      .y          (y_w[gi]),
      .S0         (s0_w[gi]),
      .S1         (s1_w[gi]),
      .busy       (busy_w[gi]),
      .done       (done_w[gi]),
      .snap       (snap_w[gi]),
      .snap_valid (sv_w[gi])
    );
  end

  task automatic chk(input string tag, input int d, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, d, obs, exp);
    end
  endtask

  task automatic check_idle(input int d, input logic [3:0] exp_snap, input logic exp_sv);
    chk("idle_sel",  d, {6'd0, s1_w[d], s0_w[d]}, 8'd0);
    chk("idle_busy", d, {7'd0, busy_w[d]}, 8'd0);
    chk("idle_done", d, {7'd0, done_w[d]}, 8'd0);
    chk("idle_snap", d, {4'd0, snap_w[d]}, {4'd0, exp_snap});
    chk("idle_sv",   d, {7'd0, sv_w[d]}, {7'd0, exp_sv});
  endtask

  // Called at a negedge. Runs one scan of instance d; ends one negedge after DONE.
  // chg_k>0 switches the mux inputs to i_new at the negedge of scan cycle chg_k.
  task automatic scan(input int d, input bit do_start, input logic [3:0] i_old,
                      input int chg_k, input logic [3:0] i_new,
                      input bit cont_next, input bit start_again);
    int dw;
    logic [3:0] exp_snap;
    dw = (d == 0) ? 1 : d;
    for (int n = 0; n < 4; n++) begin
      exp_snap[n] = (chg_k > 0 && (n + 1) * dw >= chg_k) ? i_new[n] : i_old[n];
    end
    in_v[d] = i_old;
    if (do_start) begin
      start_v[d] = 1'b1;
      @(negedge clk);
    end
    for (int k = 1; k <= 4 * dw; k++) begin
      if (k == chg_k) in_v[d] = i_new;
      start_v[d] = (k == 3) && start_again;
      if (k == 2) cont_v[d] = cont_next;
      chk("scan_sel",  d, {6'd0, s1_w[d], s0_w[d]}, 8'((k - 1) / dw));
      chk("scan_busy", d, {7'd0, busy_w[d]}, 8'd1);
      chk("scan_done", d, {7'd0, done_w[d]}, 8'd0);
      @(negedge clk);
    end
    start_v[d] = 1'b0;
    chk("done_pulse", d, {7'd0, done_w[d]}, 8'd1);
    chk("done_busy",  d, {7'd0, busy_w[d]}, 8'd0);
    chk("done_sel",   d, {6'd0, s1_w[d], s0_w[d]}, 8'd3);
    chk("done_snap",  d, {4'd0, snap_w[d]}, {4'd0, exp_snap});
    chk("done_sv",    d, {7'd0, sv_w[d]}, 8'd1);
    $display("scan dut%0d dwell=%0d I=%b chg_k=%0d I_new=%b -> snap=%b expect=%b",
             d, dw, i_old, chg_k, i_new, snap_w[d], exp_snap);
    last_snap[d] = exp_snap;
    @(negedge clk);
  endtask

  initial begin
    rst_n   = 1'b0;
    start_v = '0;
    cont_v  = '0;
    for (int d = 0; d < 3; d++) begin
      in_v[d]      = '0;
      last_snap[d] = '0;
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    for (int d = 0; d < 3; d++) check_idle(d, 4'b0000, 1'b0);

    // DWELL=2 single shot, I3..I0 = 1010.
    scan(2, 1'b1, 4'b1010, 0, 4'b0000, 1'b0, 1'b0);
    check_idle(2, 4'b1010, 1'b1);

    // DWELL=1 continuous, inputs change partway through the second scan.
    scan(1, 1'b1, 4'b0110, 0, 4'b0000, 1'b1, 1'b0);
    scan(1, 1'b0, 4'b0110, 3, 4'b1001, 1'b1, 1'b0);
    scan(1, 1'b0, 4'b1001, 0, 4'b0000, 1'b0, 1'b0);
    check_idle(1, 4'b1001, 1'b1);

    // Extra start during a scan must not queue a second one.
    scan(2, 1'b1, 4'b0101, 0, 4'b0000, 1'b0, 1'b1);
    for (int c = 0; c < 12; c++) begin
      check_idle(2, 4'b0101, 1'b1);
      @(negedge clk);
    end

    // Reset while channel 2 is selected.
    in_v[2]    = 4'b0011;
    start_v[2] = 1'b1;
    @(negedge clk);
    start_v[2] = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_rst_sel", 2, {6'd0, s1_w[2], s0_w[2]}, 8'd2);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_idle(2, 4'b0000, 1'b0);
    check_idle(1, 4'b0000, 1'b0);
    repeat (3) @(negedge clk);
    check_idle(2, 4'b0000, 1'b0);
    $display("reset mid-scan dut2 -> snap=%b sv=%b", snap_w[2], sv_w[2]);

    // DWELL=0 behaves as DWELL=1.
    scan(0, 1'b1, 4'b1111, 0, 4'b0000, 1'b0, 1'b0);
    check_idle(0, 4'b1111, 1'b1);

    // Randomized scan chains across all three instances.
    for (int it = 0; it < 20; it++) begin
      int d, dw, len;
      d   = $urandom_range(0, 2);
      dw  = (d == 0) ? 1 : d;
      len = $urandom_range(1, 3);
      for (int s = 0; s < len; s++) begin
        logic [3:0] i_old, i_new;
        int chg_k;
        i_old = 4'($urandom);
        i_new = 4'($urandom);
        chg_k = $urandom_range(0, 4 * dw);
        scan(d, (s == 0), (s == 0) ? i_old : in_v[d], chg_k, i_new,
             (s != len - 1), 1'($urandom));
      end
      check_idle(d, last_snap[d], 1'b1);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
